// File: rtl/aes_pkg.sv
// Shared AES control definitions: round count defaults,
// controller state encodings and the key-schedule RCON table.
package aes_pkg;

  localparam int unsigned NR_DEF = 10;
  localparam int unsigned CW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_FINAL  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Round 1..10 -> RCON byte; anything else is 0
  function automatic logic [7:0] rcon_byte(
    input logic [31:0] round
  );
    logic [7:0] b;
    unique case (round)
      32'd1:   b = 8'h01;
      32'd2:   b = 8'h02;
      32'd3:   b = 8'h04;
      32'd4:   b = 8'h08;
      32'd5:   b = 8'h10;
      32'd6:   b = 8'h20;
      32'd7:   b = 8'h40;
      32'd8:   b = 8'h80;
      32'd9:   b = 8'h1b;
      32'd10:  b = 8'h36;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/aes_rcon_rom.sv
// Combinational RCON lookup for the key expansion,
// indexed by the controller round counter.
module aes_rcon_rom
  import aes_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic [CW-1:0] round_i,
  output logic [31:0]   rcon_o
);

  // RCON word is the table byte in the top lane
  always_comb begin
    rcon_o = {rcon_byte(32'(round_i)), 24'h0};
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 datapath:
// one block per handshake, rounds 0..NR, result held until taken.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          SOFT_CLR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          SEL_FIRST,
  output logic          SEL_LAST,
  output logic          LOAD_EN,
  output logic          OUT_LOAD,
  output logic [CW-1:0] ROUND,
  output logic [31:0]   RCON,
  output logic          BUSY
);

  localparam logic [CW-1:0] LAST_MID = CW'(NR - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam state_e        ST_ACC   =
    (NR == 1) ? ST_FINAL : ST_ROUNDS;

  state_e        state_q, state_d;
  logic [CW-1:0] round_q, round_d;
  logic          in_ready;
  logic          accept;

  // State and round counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next state, counter and datapath strobes
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    SEL_FIRST = 1'b0;
    SEL_LAST  = 1'b0;
    LOAD_EN   = 1'b0;
    OUT_LOAD  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_ROUNDS: begin
        LOAD_EN = 1'b1;
        round_d = round_q + ONE;
        if (round_q == LAST_MID) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        SEL_LAST = 1'b1;
        OUT_LOAD = 1'b1;
        state_d  = ST_HOLD;
        round_d  = '0;
      end
      ST_HOLD: begin
        in_ready = OUT_READY;
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
    endcase
    // abort blocks the handshake in its own cycle
    if (SOFT_CLR) begin
      in_ready = 1'b0;
    end
    accept = in_ready & IN_VALID;
    // a retiring HOLD may accept in the same cycle
    if (accept) begin
      SEL_FIRST = 1'b1;
      LOAD_EN   = 1'b1;
      round_d   = ONE;
      state_d   = ST_ACC;
    end
    if (SOFT_CLR) begin
      state_d = ST_IDLE;
      round_d = '0;
    end
  end

  // Status decoded from the registered state
  always_comb begin
    IN_READY  = in_ready;
    OUT_VALID = (state_q == ST_HOLD);
    BUSY      = (state_q == ST_ROUNDS) |
                (state_q == ST_FINAL);
    ROUND     = round_q;
  end

  aes_rcon_rom #(
    .CW(CW)
  ) u_rcon (
    .round_i(round_q),
    .rcon_o (RCON)
  );

endmodule
